// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift/BCD sequencer: op codes, FSM states, result width
// and seven-segment patterns for the display scanner.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_MUL2 = 3'b001,
        OP_MUL4 = 3'b010,
        OP_DIV2 = 3'b011,
        OP_DIV4 = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Two spare bits hold x4 of the largest operand without overflow.
    function automatic int res_width(input int data_w);
        return data_w + 2;
    endfunction

    // Codes 101-111 fall through to pass (zero shifts).
    function automatic logic [1:0] shift_count(input logic [2:0] op);
        case (op)
            OP_MUL2, OP_DIV2: return 2'd1;
            OP_MUL4, OP_DIV4: return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_MUL2) || (op == OP_MUL4);
    endfunction

    // Active-high gfedcba patterns.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble iteration: add 3 to every digit >= 5, then shift
// the digit vector left by one taking bit_in at the bottom. Latency: 0 cycles.
module bcd_dd_step #(
    parameter int BCD_DIGITS = 4
) (
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    input  logic                    bit_in,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int BW = 4 * BCD_DIGITS;

    logic [BW-1:0] adj;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        assign adj[4*g +: 4] = (bcd_in[4*g +: 4] >= 4'd5) ? bcd_in[4*g +: 4] + 4'd3
                                                          : bcd_in[4*g +: 4];
    end

    // The top carry is always zero when the digit count covers the result range.
    assign bcd_out = BW'({adj, bit_in});

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: latch operand/op on START, shift one bit per clock, then serial binary-to-BCD.
// Latency N+RES_W edges to DONE; START is ignored while BUSY. Macro SHIFT_SEQ_ROUND_EN adds half-up rounding on divides.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [2:0]              OP,
    input  logic [DATA_W-1:0]       OPERAND,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [DATA_W+1:0]       RESULT,
    output logic [4*BCD_DIGITS-1:0] BCD
);

    localparam int RES_W = res_width(DATA_W);
    localparam int BW    = 4 * BCD_DIGITS;
    localparam int IW    = $clog2(RES_W);
    localparam logic [IW-1:0] ITER_LAST = IW'(RES_W - 1);

    state_e            state_q, state_d;
    logic [RES_W-1:0]  val_q;
    logic [RES_W-1:0]  sr_q;
    logic [RES_W-1:0]  shift_nxt;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_step;
    logic [IW-1:0]     iter_q;
    logic [1:0]        cnt_q;
    logic              left_q;

    always_comb begin
        shift_nxt = left_q ? (val_q << 1) : (val_q >> 1);
`ifdef SHIFT_SEQ_ROUND_EN
        // val_q[0] is the bit leaving on the final right shift; fold it in on the way out.
        if (!left_q && cnt_q == 2'd1) begin
            shift_nxt = shift_nxt + RES_W'(val_q[0]);
        end
`endif
    end

    bcd_dd_step #(.BCD_DIGITS(BCD_DIGITS)) u_step (
        .bcd_in  (bcd_q),
        .bit_in  (sr_q[RES_W-1]),
        .bcd_out (bcd_step)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = (shift_count(OP) != 2'd0) ? ST_SHIFT : ST_CONV;
            ST_SHIFT: if (cnt_q == 2'd1) state_d = ST_CONV;
            ST_CONV:  if (iter_q == ITER_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            val_q  <= '0;
            sr_q   <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            RESULT <= '0;
            BCD    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    iter_q <= '0;
                    if (START) begin
                        val_q  <= RES_W'(OPERAND);
                        sr_q   <= RES_W'(OPERAND);
                        bcd_q  <= '0;
                        cnt_q  <= shift_count(OP);
                        left_q <= is_left(OP);
                    end
                end
                ST_SHIFT: begin
                    val_q <= shift_nxt;
                    sr_q  <= shift_nxt;
                    cnt_q <= cnt_q - 2'd1;
                end
                ST_CONV: begin
                    // val_q keeps the result; sr_q is the copy consumed MSB-first.
                    bcd_q  <= bcd_step;
                    sr_q   <= sr_q << 1;
                    iter_q <= iter_q + IW'(1);
                    if (iter_q == ITER_LAST) begin
                        RESULT <= val_q;
                        BCD    <= bcd_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed, table-driven bench for shift_seq_ctrl plus hand sequences for
// held START, asynchronous reset mid-conversion and result hold.
module tb_shift_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [2:0]  OP;
    logic [7:0]  OPERAND;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  RESULT;
    logic [15:0] BCD;

    int n_applied = 0;
    int n_err     = 0;
    logic [9:0]  last_res = '0;
    logic [15:0] last_bcd = '0;

    shift_seq_ctrl dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .OP      (OP),
        .OPERAND (OPERAND),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .BCD     (BCD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  operand;
        logic [9:0]  exp_res;
        logic [15:0] exp_bcd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven #1 after an edge; edge 0 is the START-sampling edge.
    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] opd,
                          input logic [9:0] er, input logic [15:0] eb, input int el);
        int  k;
        bit  busy_ok;
        OP = op; OPERAND = opd; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; OP = ~op; OPERAND = ~opd;
        busy_ok = 1'b1;
        for (k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge CLK); #1;
            end
            if (k == 1) begin
                chk({name, " hold_result"}, 32'(RESULT), 32'(last_res));
                chk({name, " hold_bcd"}, 32'(BCD), 32'(last_bcd));
            end
            if (DONE) break;
            if (!BUSY) busy_ok = 1'b0;
        end
        chk({name, " latency"}, 32'(k), 32'(el));
        chk({name, " busy_until_done"}, 32'(busy_ok & BUSY), 32'd1);
        chk({name, " result"}, 32'(RESULT), 32'(er));
        chk({name, " bcd"}, 32'(BCD), 32'(eb));
        @(posedge CLK); #1;
        chk({name, " done_one_cycle"}, 32'(DONE), 32'd0);
        chk({name, " idle_after"}, 32'(BUSY), 32'd0);
        last_res = er;
        last_bcd = eb;
    endtask

    initial begin
        int k1, k2;
        RST_N = 1'b0; START = 1'b0; OP = 3'b000; OPERAND = 8'd0;

`ifdef SHIFT_SEQ_ROUND_EN
        vecs[5]  = '{3'b100, 8'd6,   10'd2,   16'h0002, 12};
        vecs[6]  = '{3'b100, 8'd255, 10'd64,  16'h0064, 12};
        vecs[7]  = '{3'b011, 8'd13,  10'd7,   16'h0007, 11};
        vecs[10] = '{3'b011, 8'd1,   10'd1,   16'h0001, 11};
`else
        vecs[5]  = '{3'b100, 8'd6,   10'd1,   16'h0001, 12};
        vecs[6]  = '{3'b100, 8'd255, 10'd63,  16'h0063, 12};
        vecs[7]  = '{3'b011, 8'd13,  10'd6,   16'h0006, 11};
        vecs[10] = '{3'b011, 8'd1,   10'd0,   16'h0000, 11};
`endif
        vecs[0]  = '{3'b010, 8'd255, 10'd1020, 16'h1020, 12};
        vecs[1]  = '{3'b011, 8'd200, 10'd100,  16'h0100, 11};
        vecs[2]  = '{3'b000, 8'd99,  10'd99,   16'h0099, 10};
        vecs[3]  = '{3'b111, 8'd7,   10'd7,    16'h0007, 10};
        vecs[4]  = '{3'b001, 8'd0,   10'd0,    16'h0000, 11};
        vecs[8]  = '{3'b101, 8'd128, 10'd128,  16'h0128, 10};
        vecs[9]  = '{3'b001, 8'd255, 10'd510,  16'h0510, 11};
        vecs[11] = '{3'b000, 8'd200, 10'd200,  16'h0200, 10};

        #2;
        chk("reset busy",   32'(BUSY),   32'd0);
        chk("reset done",   32'(DONE),   32'd0);
        chk("reset result", 32'(RESULT), 32'd0);
        chk("reset bcd",    32'(BCD),    32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].operand,
                   vecs[i].exp_res, vecs[i].exp_bcd, vecs[i].exp_lat);
        end

        // START held high: 7 x2, then 50 x2 accepted on the IDLE cycle after DONE.
        OP = 3'b001; OPERAND = 8'd7; START = 1'b1;
        @(posedge CLK); #1;
        OPERAND = 8'd50;
        k1 = -1; k2 = -1;
        for (int k = 0; k < 60 && k2 < 0; k++) begin
            if (k > 0) begin
                @(posedge CLK); #1;
            end
            if (DONE) begin
                if (k1 < 0) begin
                    k1 = k;
                    chk("held first result", 32'(RESULT), 32'd14);
                end else begin
                    k2 = k;
                    START = 1'b0;
                    chk("held second result", 32'(RESULT), 32'd100);
                    chk("held second bcd", 32'(BCD), 32'h0100);
                end
            end
        end
        START = 1'b0;
        chk("held first latency", 32'(k1), 32'd11);
        chk("held period", 32'(k2 - k1), 32'd13);
        @(posedge CLK); #1;
        chk("held idle after", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        chk("held no queued op", 32'(BUSY), 32'd0);

        // Asynchronous reset in the middle of CONV.
        OP = 3'b010; OPERAND = 8'd255; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("midreset busy",   32'(BUSY),   32'd0);
        chk("midreset done",   32'(DONE),   32'd0);
        chk("midreset result", 32'(RESULT), 32'd0);
        chk("midreset bcd",    32'(BCD),    32'd0);
        #2 RST_N = 1'b1;
        last_res = '0;
        last_bcd = '0;
        @(posedge CLK); #1;
        run_op("after_reset", 3'b001, 8'd3, 10'd6, 16'h0006, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

endmodule
